// File: rtl/icache_pkg.sv
// Shared types and widths for the instruction cache and its datapath helpers.
package icache_pkg;

  localparam int BLOCK_W         = 128;
  localparam int WORD_W          = 32;
  localparam int OFFSET_W        = 4;
  localparam int MEM_ADDR_W      = 28;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

endpackage

// File: rtl/icache_word_sel.sv
// Selects one 32-bit word out of a 128-bit cache block (word 0 in the low bits).
module icache_word_sel
  import icache_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  input  logic [1:0]         sel,
  output logic [WORD_W-1:0]  word
);

  logic [WORD_W-1:0] words [WORDS_PER_BLOCK];

  for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_split
    assign words[gi] = block[gi*WORD_W +: WORD_W];
  end

  assign word = words[sel];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with single-block refill on miss.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = $clog2(NUM_LINES),
  parameter int TAG_W     = MEM_ADDR_W - INDEX_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [31:0]           address,
  output logic [WORD_W-1:0]     instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  state_t                state_reg;
  state_t                state_next;
  logic                  mem_read_reg;
  logic [NUM_LINES-1:0]  valid_reg;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [BLOCK_W-1:0]    data_mem [NUM_LINES];

  logic [INDEX_W-1:0]    idx;
  logic [TAG_W-1:0]      addr_tag;
  logic                  hit;
  logic [WORD_W-1:0]     sel_word;
  logic                  unused_addr_bits;

  assign idx              = address[OFFSET_W +: INDEX_W];
  assign addr_tag         = address[31:OFFSET_W+INDEX_W];
  assign unused_addr_bits = ^address[1:0];
  assign hit              = valid_reg[idx] && (tag_mem[idx] == addr_tag);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (read && !hit) state_next = MEM_READ;
      MEM_READ: if (!mem_busywait) state_next = UPDATE;
      UPDATE:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // mem_read is a flop mirroring "in MEM_READ" so the memory sees a clean strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      mem_read_reg <= 1'b0;
      valid_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      mem_read_reg <= (state_next == MEM_READ);
      if (state_reg == UPDATE) valid_reg[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; validity alone decides a hit.
  always_ff @(posedge clock) begin
    if (state_reg == UPDATE) begin
      data_mem[idx] <= mem_readdata;
      tag_mem[idx]  <= addr_tag;
    end
  end

  icache_word_sel u_word_sel (
    .block (data_mem[idx]),
    .sel   (address[3:2]),
    .word  (sel_word)
  );

  assign instruction = reset ? sel_word : '0;
  assign busywait    = reset && read && !((state_reg == IDLE) && hit);
  assign mem_read    = mem_read_reg;
  assign mem_address = mem_read_reg ? address[31:OFFSET_W] : '0;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if ((state_reg == IDLE) && read) begin
      if (hit && (hit_count_reg != '1))
        hit_count_reg <= hit_count_reg + 32'd1;
      if (!hit && (miss_count_reg != '1))
        miss_count_reg <= miss_count_reg + 32'd1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Randomised self-checking bench for icache_direct_mapped against a line-map model.
// Define ICACHE_PERF_CNT_EN to also check the hit/miss counters.
module tb_icache_direct_mapped;

  localparam int INDEX_W = 3;
  localparam int NLINES  = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          read = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   instruction;
  logic          busywait;
  logic          mem_read;
  logic [27:0]   mem_address;
  logic [127:0]  mem_readdata = '0;
  logic          mem_busywait = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Reference model: which memory block each line currently holds.
  bit          line_valid [NLINES];
  logic [27:0] line_blk   [NLINES];

  // Memory responder configuration/state.
  int mem_lat = 0;
  int busy_left = 0;
  bit req_active = 0;

  icache_direct_mapped dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [27:0] b, input logic [1:0] w);
    return {b, 2'b00, w} ^ 32'hC3A5_96F0;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    return {mem_word(b, 2'd3), mem_word(b, 2'd2), mem_word(b, 2'd1), mem_word(b, 2'd0)};
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'(a[4 +: INDEX_W]);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return line_valid[line_of(a)] && (line_blk[line_of(a)] == a[31:4]);
  endfunction

  // Instruction memory: holds busywait high for mem_lat cycles per request.
  always @(negedge clock) begin
    if (mem_read) begin
      if (!req_active) begin
        req_active   = 1'b1;
        busy_left    = mem_lat;
        mem_readdata = mem_block(mem_address);
      end
      if (busy_left > 0) begin
        mem_busywait = 1'b1;
        busy_left--;
      end else begin
        mem_busywait = 1'b0;
      end
    end else begin
      req_active   = 1'b0;
      mem_busywait = 1'b0;
    end
  end

  // CPU protocol: address must not move across consecutive stalled cycles.
  logic        prev_busy = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(posedge clock) begin
    assert (!(busywait && prev_busy && (address !== prev_addr)))
      else $error("protocol: address changed while stalled");
    prev_busy = busywait;
    prev_addr = address;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic clear_model();
    for (int i = 0; i < NLINES; i++) line_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One CPU fetch; follows a miss through refill and checks the penalty.
  task automatic do_fetch(input logic [31:0] a, input int lat);
    bit exp_hit;
    int waited;
    @(negedge clock);
    mem_lat = lat;
    read    = 1'b1;
    address = a;
    #1;
    exp_hit = model_hit(a);
    n_vec++;
    if (busywait !== !exp_hit) begin
      n_err++;
      $display("FAIL fetch_busy addr=%h got=%b want=%b", a, busywait, !exp_hit);
    end
    if (!exp_hit) begin
      exp_misses++;
      @(negedge clock); #1;
      n_vec++;
      if (mem_read !== 1'b1 || mem_address !== a[31:4]) begin
        n_err++;
        $display("FAIL fetch_memreq addr=%h got mem_read=%b mem_address=%h want 1/%h",
                 a, mem_read, mem_address, a[31:4]);
      end
      waited = 1;
      while (busywait === 1'b1 && waited < 200) begin
        @(negedge clock); #1;
        waited++;
      end
      n_vec++;
      if (waited != lat + 3) begin
        n_err++;
        $display("FAIL fetch_penalty addr=%h got=%0d want=%0d stalled cycles", a, waited, lat + 3);
      end
      line_valid[line_of(a)] = 1'b1;
      line_blk[line_of(a)]   = a[31:4];
    end
    exp_hits++;
    n_vec++;
    if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== mem_word(a[31:4], a[3:2])) begin
      n_err++;
      $display("FAIL fetch_data addr=%h got busy=%b mem_read=%b instr=%h want 0/0/%h",
               a, busywait, mem_read, instruction, mem_word(a[31:4], a[3:2]));
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    read = 1'b1;
    address = 32'h0000_1234;
    clear_model();
    repeat (2) @(negedge clock);
    #1;
    n_vec++;
    if (busywait !== 1'b0 || instruction !== 32'h0 || mem_read !== 1'b0 || mem_address !== 28'h0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b instr=%h mem_read=%b mem_addr=%h want all 0",
               busywait, instruction, mem_read, mem_address);
    end
`ifdef ICACHE_PERF_CNT_EN
    n_vec++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counters got hit=%0d miss=%0d want 0/0", hit_count, miss_count);
    end
`endif
    @(negedge clock);
    read = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h0000_0000, 16);
  endtask

  task automatic test_back_to_back();
    for (int w = 1; w < 4; w++) begin
      logic [31:0] a;
      a = 32'(w * 4);
      @(negedge clock);
      address = a;
      #1;
      exp_hits++;
      n_vec++;
      if (busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== mem_word(28'h0, 2'(w))) begin
        n_err++;
        $display("FAIL b2b_hit addr=%h got busy=%b mem_read=%b instr=%h want 0/0/%h",
                 a, busywait, mem_read, instruction, mem_word(28'h0, 2'(w)));
      end
    end
    @(negedge clock);
    read = 1'b0;
    #1;
`ifdef ICACHE_PERF_CNT_EN
    n_vec++;
    if (hit_count !== 32'd4 || miss_count !== 32'd1) begin
      n_err++;
      $display("FAIL perf_after_fill got hit=%0d miss=%0d want 4/1", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_0080, 3);
    n_vec++;
    if (model_hit(32'h0000_0000)) begin
      n_err++;
      $display("FAIL conflict_model got line0 still holding block 0 want evicted");
    end
    do_fetch(32'h0000_0000, 2);
  endtask

  task automatic test_reset_abort();
    @(negedge clock);
    mem_lat = 10;
    read = 1'b1;
    address = 32'h0000_0010;
    repeat (2) @(negedge clock);
    #1;
    n_vec++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pre_mem_read got=%b want=1", mem_read);
    end
    reset = 1'b0;
    read = 1'b0;
    #1;
    clear_model();
    n_vec++;
    if (mem_read !== 1'b0 || busywait !== 1'b0 || instruction !== 32'h0) begin
      n_err++;
      $display("FAIL abort_async got mem_read=%b busy=%b instr=%h want 0/0/0",
               mem_read, busywait, instruction);
    end
    @(negedge clock);
    reset = 1'b1;
    do_fetch(32'h0000_0000, 1);
  endtask

  task automatic test_idle_no_read();
    @(negedge clock);
    read = 1'b0;
    address = 32'h0000_1230;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      n_vec++;
      if (busywait !== 1'b0 || mem_read !== 1'b0) begin
        n_err++;
        $display("FAIL idle_no_read cycle=%0d got busy=%b mem_read=%b want 0/0", c, busywait, mem_read);
      end
    end
  endtask

  task automatic test_read_drop();
    logic [31:0] a;
    a = 32'h0000_0200;
    @(negedge clock);
    mem_lat = 2;
    read = 1'b1;
    address = a;
    if (!model_hit(a)) exp_misses++;
    @(negedge clock); #1;
    n_vec++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL drop_mem_read got=%b want=1", mem_read);
    end
    read = 1'b0;
    #1;
    n_vec++;
    if (busywait !== 1'b0) begin
      n_err++;
      $display("FAIL drop_busy got=%b want=0", busywait);
    end
    repeat (6) @(negedge clock);
    line_valid[line_of(a)] = 1'b1;
    line_blk[line_of(a)]   = a[31:4];
    read = 1'b1;
    address = a | 32'h8;
    #1;
    exp_hits++;
    n_vec++;
    if (busywait !== 1'b0 || instruction !== mem_word(a[31:4], 2'd2)) begin
      n_err++;
      $display("FAIL drop_fill_done got busy=%b instr=%h want 0/%h",
               busywait, instruction, mem_word(a[31:4], 2'd2));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      do_fetch(a, int'($urandom_range(0, 4)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        read = 1'b0;
        #1;
        n_vec++;
        if (busywait !== 1'b0) begin
          n_err++;
          $display("FAIL random_gap got busy=%b want 0", busywait);
        end
      end
    end
    @(negedge clock);
    read = 1'b0;
    #1;
`ifdef ICACHE_PERF_CNT_EN
    n_vec++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      n_err++;
      $display("FAIL perf_final got hit=%0d miss=%0d want %0d/%0d",
               hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_reset_abort();
    test_idle_no_read();
    test_read_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
